weighted_roundrobin_arbiter: RTL and testbench

Weighted round-robin arbiter with transaction locking. It shares one `bus_mux` master port among N slave-side requesters. Each requester gets a programmable number of back-to-back transactions (its weight) before priority rotates. A grant is held from issue until the mux reports that the transaction is complete, and the block hands over to the next requester with no idle cycle.

---
 rtl/weighted_roundrobin_arbiter.sv | 147 ++++++++++++++
 tb/tb_weighted_roundrobin_arbiter.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/weighted_roundrobin_arbiter.sv
// Weighted round-robin arbiter with per-requester burst credit.
// Grants lock until i_done and hand over with no idle cycle.
module weighted_roundrobin_arbiter #(
  parameter int N = 4,
  parameter int W = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [N-1:0]         i_request,
  input  logic [N*W-1:0]       i_weight,
  input  logic                 i_done,
  output logic [N-1:0]         o_grant,
  output logic [$clog2(N)-1:0] o_grant_index,
  output logic                 o_busy
);

  localparam int PW  = $clog2(N);
  localparam int PW1 = PW + 1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] p_q, p_d;
  logic [W-1:0]  c_q, c_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [PW-1:0] idx_q, idx_d;
  logic          busy_q, busy_d;

  logic          done_ev;
  logic          arb_ev;
  logic [W-1:0]  c_dec;
  logic [PW-1:0] p_inc;
  logic [PW-1:0] p_eff;
  logic [W-1:0]  c_eff;
  logic          found;
  logic [PW-1:0] win;
  logic [PW1-1:0] ks;
  logic [W-1:0]  wt [N];
  logic [W-1:0]  w_sel;
  logic [W-1:0]  w_eff;
  logic          ld;

  always_comb begin
    for (int k = 0; k < N; k++) begin
      wt[k] = i_weight[k*W +: W];
    end
  end

  // Completion is applied first so selection sees post-done p and c.
  always_comb begin
    done_ev = (state_q == BUSY) && i_done;
    c_dec   = c_q - 1'b1;
    p_inc   = (p_q == PW'(N-1)) ? '0 : p_q + 1'b1;
    p_eff   = p_q;
    c_eff   = c_q;
    if (done_ev) begin
      c_eff = c_dec;
      if (c_dec == '0) begin
        p_eff = p_inc;
      end
    end
  end

  always_comb begin
    found = 1'b0;
    win   = '0;
    ks    = '0;
    for (int i = 0; i < N; i++) begin
      ks = {1'b0, p_eff} + PW1'(i);
      if (ks >= PW1'(N)) begin
        ks = ks - PW1'(N);
      end
      if (!found && i_request[ks[PW-1:0]]) begin
        found = 1'b1;
        win   = ks[PW-1:0];
      end
    end
  end

  always_comb begin
    w_sel = wt[win];
    w_eff = (w_sel == '0) ? W'(1) : w_sel;
    ld    = (win != p_eff) || (c_eff == '0);
  end

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    c_d     = c_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    arb_ev  = 1'b0;
    case (state_q)
      IDLE: arb_ev = |i_request;
      BUSY: arb_ev = i_done;
      default: arb_ev = 1'b0;
    endcase
    if (done_ev) begin
      p_d = p_eff;
      c_d = c_eff;
    end
    if (arb_ev) begin
      if (found) begin
        state_d = BUSY;
        if (ld) begin
          p_d = win;
          c_d = w_eff;
        end
        grant_d = N'(1) << win;
        idx_d   = win;
        busy_d  = 1'b1;
      end else begin
        state_d = IDLE;
        grant_d = '0;
        idx_d   = '0;
        busy_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      p_q     <= '0;
      c_q     <= '0;
      grant_q <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      c_q     <= c_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
    end
  end

  assign o_grant       = grant_q;
  assign o_grant_index = idx_q;
  assign o_busy        = busy_q;

endmodule

// File: tb/tb_weighted_roundrobin_arbiter.sv
// Directed bench for weighted_roundrobin_arbiter.
// Drives and samples 1 time unit after each rising edge.
module tb_weighted_roundrobin_arbiter;

  logic        i_clk;
  logic        i_rst_n;
  logic [3:0]  i_request;
  logic [15:0] i_weight;
  logic        i_done;
  logic [3:0]  o_grant;
  logic [1:0]  o_grant_index;
  logic        o_busy;

  int n_tests;
  int n_fail;

  weighted_roundrobin_arbiter #(
    .N(4),
    .W(4)
  ) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_request    (i_request),
    .i_weight     (i_weight),
    .i_done       (i_done),
    .o_grant      (o_grant),
    .o_grant_index(o_grant_index),
    .o_busy       (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] req,
                          input logic [15:0] wt,
                          input logic d);
    i_rst_n   = 1'b0;
    i_request = req;
    i_weight  = wt;
    i_done    = d;
    tick();
    i_rst_n = 1'b1;
  endtask

  task automatic expect_grant(input string tag, input int idx);
    logic [3:0] oh;
    oh = 4'(1 << idx);
    check({tag, "_grant"}, 32'(o_grant), 32'(oh));
    check({tag, "_idx"}, 32'(o_grant_index), 32'(idx));
    check({tag, "_busy"}, 32'(o_busy), 32'd1);
  endtask

  task automatic expect_idle(input string tag);
    check({tag, "_grant"}, 32'(o_grant), 32'd0);
    check({tag, "_idx"}, 32'(o_grant_index), 32'd0);
    check({tag, "_busy"}, 32'(o_busy), 32'd0);
  endtask

  int rot_seq[8]  = '{0, 0, 1, 2, 3, 0, 0, 1};
  int skip_seq[4] = '{1, 3, 1, 3};
  int mid_seq[6]  = '{0, 0, 0, 0, 0, 1};

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    i_rst_n   = 1'b0;
    i_request = 4'b1111;
    i_weight  = 16'h1111;
    i_done    = 1'b0;

    // reset holds outputs low despite requests
    #2;
    expect_idle("rst_async");
    tick();
    tick();
    expect_idle("rst_held");
    i_rst_n = 1'b1;
    tick();
    expect_grant("rst_first", 0);

    // weights {3:1,2:1,1:1,0:2}, done held high
    do_reset(4'b0000, 16'h1112, 1'b1);
    i_request = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      tick();
      expect_grant($sformatf("rot%0d", i), rot_seq[i]);
    end

    // zero weights behave as 1, idle requesters skipped
    do_reset(4'b1010, 16'h0000, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_grant($sformatf("skip%0d", i), skip_seq[i]);
    end

    // lock holds grant while done is low
    do_reset(4'b0010, 16'h1111, 1'b0);
    tick();
    expect_grant("lock_start", 1);
    i_request = 4'b1101;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("lock_hold%0d", i), 32'(o_grant), 32'h2);
    end
    i_done = 1'b1;
    tick();
    expect_grant("lock_next", 2);
    i_done = 1'b0;

    // drain: requester 2 weight 3, request dropped on last done
    do_reset(4'b0100, 16'h1311, 1'b0);
    tick();
    expect_grant("drain_g0", 2);
    i_done = 1'b1;
    tick();
    expect_grant("drain_g1", 2);
    tick();
    expect_grant("drain_g2", 2);
    i_request = 4'b0000;
    tick();
    expect_idle("drain_idle");
    tick();
    tick();
    expect_idle("drain_done_idle");
    i_done    = 1'b0;
    i_request = 4'b0100;
    tick();
    expect_grant("drain_regrant", 2);

    // reset mid-burst restores fresh credit and p=0
    do_reset(4'b0001, 16'h1115, 1'b0);
    tick();
    expect_grant("mid_g0", 0);
    i_done = 1'b1;
    tick();
    tick();
    expect_grant("mid_g2", 0);
    i_rst_n = 1'b0;
    #2;
    expect_idle("mid_rst");
    i_request = 4'b0011;
    tick();
    i_rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      expect_grant($sformatf("mid_post%0d", i), mid_seq[i]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
